// File: rtl/pipeline_hazard_ctrl_if.sv
// Control bundle between the ID/EX pipeline front end and the hazard controller.
// The master drives instruction/hazard info; the slave returns stall/flush controls.
interface pipeline_hazard_ctrl_if #(
   parameter int unsigned REG_ADDR_W = 4
);
   logic                  id_valid;
   logic [REG_ADDR_W-1:0] id_rs1;
   logic [REG_ADDR_W-1:0] id_rs2;
   logic                  id_uses_rs1;
   logic                  id_uses_rs2;
   logic                  id_is_vec;
   logic                  ex_valid;
   logic                  ex_is_load;
   logic [REG_ADDR_W-1:0] ex_rd;
   logic                  branch_taken;
   logic                  ext_halt;
   logic                  stop;
   logic                  pc_en;
   logic                  if_id_flush;
   logic                  id_ex_bubble;
   logic                  ex_hold;
   logic [1:0]            state;

   modport master (
      output id_valid, id_rs1, id_rs2, id_uses_rs1, id_uses_rs2, id_is_vec,
             ex_valid, ex_is_load, ex_rd, branch_taken, ext_halt,
      input  stop, pc_en, if_id_flush, id_ex_bubble, ex_hold, state
   );

   modport slave (
      input  id_valid, id_rs1, id_rs2, id_uses_rs1, id_uses_rs2, id_is_vec,
             ex_valid, ex_is_load, ex_rd, branch_taken, ext_halt,
      output stop, pc_en, if_id_flush, id_ex_bubble, ex_hold, state
   );
endinterface

// File: rtl/pipeline_hazard_ctrl.sv
// Stall/flush controller: load-use stalls, multi-cycle vector occupancy of EX,
// taken-branch flushes and external halt, driving IF/ID, PC and ID/EX controls.
module pipeline_hazard_ctrl #(
   parameter int unsigned REG_ADDR_W = 4,
   parameter int unsigned VEC_LAT    = 4
) (
   input  logic                  clk,
   input  logic                  reset,
   pipeline_hazard_ctrl_if.slave hz
);
   typedef enum logic [1:0] {
      RUN  = 2'd0,
      VEC  = 2'd1,
      HALT = 2'd2
   } state_t;

   localparam bit         VEC_MULTI = (VEC_LAT > 1);
   localparam logic [3:0] VCNT_INIT = VEC_MULTI ? 4'(VEC_LAT - 2) : 4'd0;

   state_t                state_q, state_d;
   logic [3:0]            vcnt_q, vcnt_d;
   logic [REG_ADDR_W-1:0] rd;
   logic                  load_use;

   assign rd = hz.ex_rd;

   // Register 0 is hardwired, so a load targeting it can never create a hazard.
   always_comb begin
      load_use = hz.id_valid & hz.ex_valid & hz.ex_is_load & (rd != '0) &
                 ((hz.id_uses_rs1 & (hz.id_rs1 == rd)) |
                  (hz.id_uses_rs2 & (hz.id_rs2 == rd)));
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_q <= RUN;
         vcnt_q  <= '0;
      end else begin
         state_q <= state_d;
         vcnt_q  <= vcnt_d;
      end
   end

   always_comb begin
      state_d = state_q;
      vcnt_d  = vcnt_q;
      unique case (state_q)
         RUN: begin
            if (hz.branch_taken) begin
               state_d = RUN;
            end else if (hz.ext_halt) begin
               state_d = HALT;
            end else if (load_use) begin
               state_d = RUN;
            end else if (hz.id_valid && hz.id_is_vec && VEC_MULTI) begin
               state_d = VEC;
               vcnt_d  = VCNT_INIT;
            end
         end
         VEC: begin
            if (vcnt_q == '0) begin
               state_d = hz.ext_halt ? HALT : RUN;
            end else begin
               vcnt_d = vcnt_q - 4'd1;
            end
         end
         HALT: begin
            if (!hz.ext_halt) state_d = RUN;
         end
         default: begin
            state_d = RUN;
            vcnt_d  = '0;
         end
      endcase
   end

   // Outputs are forced low while reset is held, independent of the state register.
   always_comb begin
      hz.stop         = 1'b0;
      hz.pc_en        = 1'b0;
      hz.if_id_flush  = 1'b0;
      hz.id_ex_bubble = 1'b0;
      hz.ex_hold      = 1'b0;
      hz.state        = 2'd0;
      if (!reset) begin
         hz.state = state_q;
         unique case (state_q)
            RUN: begin
               if (hz.branch_taken) begin
                  hz.if_id_flush  = 1'b1;
                  hz.id_ex_bubble = 1'b1;
                  hz.pc_en        = 1'b1;
               end else if (hz.ext_halt || load_use) begin
                  hz.stop         = 1'b1;
                  hz.id_ex_bubble = 1'b1;
               end else begin
                  hz.pc_en = 1'b1;
               end
            end
            VEC: begin
               hz.stop    = 1'b1;
               hz.ex_hold = 1'b1;
            end
            HALT: begin
               hz.stop         = 1'b1;
               hz.id_ex_bubble = 1'b1;
            end
            default: begin
               hz.stop = 1'b0;
            end
         endcase
      end
   end
endmodule
